// File: rtl/radio_ctrl_sync.sv
// Destination-side capture of asynchronous radio control levels crossing out of a
// switchable power domain: per-channel synchroniser and stability filter, plus isolation clamp/hold.
module radio_ctrl_sync #(
    parameter int              N_CH        = 2,
    parameter int              SYNC_STAGES = 2,
    parameter int              FILTER_LEN  = 3,
    parameter int              SETTLE_LEN  = 4,
    parameter logic [N_CH-1:0] CLAMP_VAL   = '0,
    parameter bit              HOLD_LAST   = 1'b0
) (
    input  logic            ck,
    input  logic            arst,
    input  logic            isolate_i,
    input  logic [N_CH-1:0] ctrl_async_i,
    output logic [N_CH-1:0] ctrl_q_o,
    output logic [N_CH-1:0] ctrl_chg_o,
    output logic            active_o,
    output logic [1:0]      state_dbg
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int SW = $clog2(SETTLE_LEN + 1);

    typedef enum logic [1:0] {
        ST_ISOLATED = 2'd0,
        ST_SETTLING = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_t;

    state_t                                 state;
    logic [SW-1:0]                          settle_cnt;
    logic [SYNC_STAGES-1:0][N_CH-1:0]       sync_q;
    logic [N_CH-1:0]                        s;
    logic [N_CH-1:0][FW-1:0]                fc;
    logic [N_CH-1:0]                        q_prev;

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ctrl_async_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Isolation wins over every transition; the settle count restarts on each release.
    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            state      <= ST_ISOLATED;
            settle_cnt <= '0;
            active_o   <= 1'b0;
        end else if (isolate_i) begin
            state    <= ST_ISOLATED;
            active_o <= 1'b0;
        end else begin
            case (state)
                ST_ISOLATED: begin
                    state      <= ST_SETTLING;
                    settle_cnt <= '0;
                end
                ST_SETTLING: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SW'(SETTLE_LEN - 1)) begin
                        state    <= ST_ACTIVE;
                        active_o <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    state <= ST_ACTIVE;
                end
                default: begin
                    state    <= ST_ISOLATED;
                    active_o <= 1'b0;
                end
            endcase
        end
    end

    // A new synced level is accepted only after FILTER_LEN consecutive mismatching cycles.
    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            ctrl_q_o <= CLAMP_VAL;
            fc       <= '0;
        end else if (isolate_i) begin
            fc <= '0;
            if (!HOLD_LAST) begin
                ctrl_q_o <= CLAMP_VAL;
            end
        end else if (state != ST_ACTIVE) begin
            fc <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (s[i] == ctrl_q_o[i]) begin
                    fc[i] <= '0;
                end else if (fc[i] == FW'(FILTER_LEN - 1)) begin
                    ctrl_q_o[i] <= s[i];
                    fc[i]       <= '0;
                end else begin
                    fc[i] <= fc[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            q_prev <= CLAMP_VAL;
        end else begin
            q_prev <= ctrl_q_o;
        end
    end

    assign ctrl_chg_o = ctrl_q_o ^ q_prev;
    assign state_dbg  = state;

endmodule

// File: doc/radio_ctrl_sync.md
# radio_ctrl_sync

Parametrised, isolation-aware capture stage for N asynchronous radio control levels, such as radio enable and RX enable, entering an always-on domain from a switchable domain. It sits on the destination side of the power-domain crossing in the timing engine. Each channel gets a synchroniser and a stability filter, and the block as a whole forces a clamp or hold while the source is isolated. After isolation is released, a settling interval runs before captured values are trusted again.

## Interface
Parameters:
- N_CH, 2: number of control channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- FILTER_LEN, 3: consecutive cycles a new synced value must persist before it is accepted (≥1).
- SETTLE_LEN, 4: cycles spent in SETTLING after isolation release (≥1).
- CLAMP_VAL, '0: N_CH-bit value forced on ctrl_q_o during isolation.
- HOLD_LAST, 0: 1 means ctrl_q_o holds its last value during isolation instead of loading CLAMP_VAL.

Ports:
- ck  in  1  clock.
- arst  in  1  reset, asynchronous, active-high.
- isolate_i  in  1  source-domain isolation request; synchronous to ck.
- ctrl_async_i  in  N_CH  raw control levels from the source domain (asynchronous).
- ctrl_q_o  out  N_CH  filtered, registered control levels.
- ctrl_chg_o  out  N_CH  bit i is high for exactly the cycle in which ctrl_q_o[i] differs from its previous-cycle value.
- active_o  out  1  high while the state is ACTIVE.

## Operation
- Synchroniser: a chain of SYNC_STAGES flops per channel, all reset to 0. The last stage is s[i].
- FSM states are ISOLATED, SETTLING and ACTIVE. The reset state is ISOLATED.
  - From any state, isolate_i=1 moves the FSM to ISOLATED. This has priority over all other transitions.
  - ISOLATED moves to SETTLING when isolate_i=0. The settle counter loads 0.
  - SETTLING increments the settle counter each cycle. When the counter equals SETTLE_LEN-1 and isolate_i=0, the FSM moves to ACTIVE.
  - ACTIVE stays ACTIVE until isolate_i=1.
- ctrl_q_o update, in priority order:
  - isolate_i=1: load CLAMP_VAL, or hold when HOLD_LAST=1.
  - State ISOLATED or SETTLING: hold.
  - State ACTIVE: per-channel filter, described next.
- Per-channel filter (only in ACTIVE):
  - The counter fc[i] is clog2(FILTER_LEN+1) bits wide.
  - If s[i]==ctrl_q_o[i], fc[i] is set to 0.
  - Else if fc[i]==FILTER_LEN-1, ctrl_q_o[i] is set to s[i] and fc[i] is set to 0.
  - Else fc[i] increments.
- All fc[i] clear whenever the state is not ACTIVE or isolate_i=1.
- Channels are fully independent, so several may update in the same cycle.
- ctrl_chg_o = ctrl_q_o XOR a registered copy of ctrl_q_o. Clamp-induced changes also pulse ctrl_chg_o.

## Timing
- Reset values:
  - ctrl_q_o = CLAMP_VAL (in both HOLD_LAST modes).
  - ctrl_chg_o = 0; the previous-value register resets to CLAMP_VAL.
  - active_o = 0; state ISOLATED.
  - All counters and synchroniser flops = 0.
- After arst is released with isolate_i=0:
  - SETTLING after the first edge.
  - ACTIVE after SETTLE_LEN+1 edges; 5 with defaults.
- Isolation assertion:
  - isolate_i sampled high at edge k: ctrl_q_o = CLAMP_VAL and active_o = 0 after edge k.
  - Any in-flight filter count is discarded.
- Isolation release:
  - isolate_i sampled low at edge j: SETTLING after j, ACTIVE after edge j+SETTLE_LEN.
  - Re-assertion during SETTLING returns the FSM to ISOLATED and restarts the settle count on the next release.
- Capture latency in ACTIVE:
  - A stable input change before edge 0 appears on s after edge SYNC_STAGES-1.
  - It appears on ctrl_q_o after edge SYNC_STAGES+FILTER_LEN-1, i.e. SYNC_STAGES+FILTER_LEN edges; 5 with defaults.
  - ctrl_chg_o pulses in that same cycle, for one cycle.
- Glitch rejection: a mismatch lasting fewer than FILTER_LEN synced cycles resets fc and leaves ctrl_q_o unchanged.
- A mismatch already present on entry to ACTIVE is accepted FILTER_LEN edges after the ACTIVE transition edge.
- arst asserted mid-operation forces the reset values immediately, without waiting for a clock edge.

## Test plan
- Reset and power-up settle (defaults):
  - Stimulus: arst pulse with isolate_i=0 and ctrl_async_i=2'b11.
  - Required: ctrl_q_o=00 through reset; active_o rises after edge 5.
  - Required: ctrl_q_o=11 with ctrl_chg_o=11 for one cycle three edges later.
- Latency and glitch rejection (defaults, ACTIVE, ctrl_q_o=00):
  - Stimulus: set ctrl_async_i[0]=1 permanently.
  - Required: ctrl_q_o[0]=1 after exactly 5 edges.
  - Stimulus: a separate 2-cycle pulse on ctrl_async_i[1].
  - Required: no change on ctrl_q_o[1] and no ctrl_chg_o[1] pulse.
- Isolation with clamp (CLAMP_VAL=2'b10):
  - Stimulus: from ctrl_q_o=01, assert isolate_i for 10 cycles.
  - Required: ctrl_q_o=10 after the first edge; ctrl_chg_o=11 for one cycle; active_o=0.
  - Stimulus: release isolate_i.
  - Required: active_o=1 after SETTLE_LEN edges; ctrl_q_o returns to 01 FILTER_LEN edges later.
- HOLD_LAST=1:
  - Stimulus: isolate_i asserted with ctrl_q_o=11; toggle ctrl_async_i during isolation and during SETTLING.
  - Required: ctrl_q_o stays 11 and ctrl_chg_o stays 0 throughout.
- Isolation re-asserted mid-SETTLING and mid-filter:
  - Stimulus: isolate_i high at settle count 2.
  - Required: the FSM returns to ISOLATED, and the next release needs the full SETTLE_LEN again.
  - Stimulus: isolation during a filter count of 2.
  - Required: no update to ctrl_q_o from the discarded count.
- Wide configuration (N_CH=8, SYNC_STAGES=3, FILTER_LEN=1):
  - Stimulus: walking-one on ctrl_async_i.
  - Required: each bit reaches ctrl_q_o after 4 edges, with exactly one ctrl_chg_o pulse per bit change.
